// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and
// the counter/index width helpers.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REL    = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    function automatic int cnt_width(input int hold_cyc, input int step_cyc);
        int max_cyc;
        max_cyc = (hold_cyc > step_cyc) ? hold_cyc : step_cyc;
        return $clog2(max_cyc + 1);
    endfunction

    function automatic int idx_width(input int num_dom);
        return $clog2(num_dom + 1);
    endfunction

endpackage

// File: rtl/edge_det_rise.sv
// Rising-edge detector: registers the input and flags a low-to-high change.
module edge_det_rise (
    input  logic clk_i,
    input  logic rst_n_sync_i,
    input  logic din_s,
    output logic rise_s
);

    logic din_d_r;

    // one-cycle delayed copy of the input, cleared while in reset
    always_ff @(posedge clk_i or negedge rst_n_sync_i) begin
        if (!rst_n_sync_i) begin
            din_d_r <= 1'b0;
        end else begin
            din_d_r <= din_s;
        end
    end

    assign rise_s = din_s & ~din_d_r;

endmodule

// File: rtl/reset_seq_gen.sv
// Reset sequencer: holds all domains in reset, releases them one at a time in
// index order, and re-runs the sequence on a software request.
module reset_seq_gen
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOM  = 2,
    parameter int HOLD_CYC = 16,
    parameter int STEP_CYC = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_sync_i,
    input  logic               sw_rst_req_i,
    output logic               sw_rst_ack_o,
    output logic [NUM_DOM-1:0] rst_n_o,
    output logic               rst_done_o,
    output logic [1:0]         state_o
);

    localparam int CW = cnt_width(HOLD_CYC, STEP_CYC);
    localparam int IW = idx_width(NUM_DOM);

    localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]      STEP_LAST = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_DOM - 1);
    localparam logic [IW-1:0]      IDX_ONE   = IW'(1);
    localparam logic [NUM_DOM-1:0] DOM_ONE   = NUM_DOM'(1);

    state_e             state_r;
    logic [CW-1:0]      cnt_r;
    logic [IW-1:0]      idx_r;
    logic [NUM_DOM-1:0] rst_n_r;
    logic               done_r;
    logic               ack_r;
    logic               sw_pend_r;
    logic               trig_s;

    edge_det_rise u_req_edge (
        .clk_i        (clk_i),
        .rst_n_sync_i (rst_n_sync_i),
        .din_s        (sw_rst_req_i),
        .rise_s       (trig_s)
    );

    // sequencer FSM with the hold/step counter and all registered outputs
    always_ff @(posedge clk_i or negedge rst_n_sync_i) begin
        if (!rst_n_sync_i) begin
            state_r   <= ST_ASSERT;
            cnt_r     <= '0;
            idx_r     <= '0;
            rst_n_r   <= '0;
            done_r    <= 1'b0;
            ack_r     <= 1'b0;
            sw_pend_r <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                ST_ASSERT: begin
                    state_r <= ST_HOLD;
                    cnt_r   <= '0;
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        rst_n_r <= DOM_ONE;
                        cnt_r   <= '0;
                        idx_r   <= IDX_ONE;
                        if (NUM_DOM == 1) begin
                            state_r   <= ST_RUN;
                            done_r    <= 1'b1;
                            ack_r     <= sw_pend_r;
                            sw_pend_r <= 1'b0;
                        end else begin
                            state_r <= ST_REL;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_REL: begin
                    if (cnt_r == STEP_LAST) begin
                        rst_n_r <= rst_n_r | (DOM_ONE << idx_r);
                        cnt_r   <= '0;
                        idx_r   <= idx_r + IDX_ONE;
                        if (idx_r == IDX_LAST) begin
                            state_r   <= ST_RUN;
                            done_r    <= 1'b1;
                            ack_r     <= sw_pend_r;
                            sw_pend_r <= 1'b0;
                        end else begin
                            state_r <= ST_REL;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // only a fresh rising request restarts; ST_ASSERT is skipped
                    if (trig_s) begin
                        rst_n_r   <= '0;
                        done_r    <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= ST_HOLD;
                        sw_pend_r <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_ASSERT;
                end
            endcase
        end
    end

    assign rst_n_o      = rst_n_r;
    assign rst_done_o   = done_r;
    assign sw_rst_ack_o = ack_r;
    assign state_o      = state_r;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Scoreboard bench for reset_seq_gen: three parameter sets share clock, reset and
// request; a timing model predicts every output change, a monitor matches them.
module tb_reset_seq_gen;

    localparam int NI = 3;
    localparam int ND [NI] = '{2, 1, 4};
    localparam int HC [NI] = '{16, 1, 16};
    localparam int SC [NI] = '{4, 1, 3};

    typedef struct packed {
        int         inst;
        int         edge_n;
        logic [7:0] val;
    } ev_t;

    logic       clk_tb = 1'b0;
    logic       rst_n_sync;
    logic       sw_req;
    logic [7:0] dut_val [NI];
    ev_t        sb_q [$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         stim_done = 1'b0;

    always #5 clk_tb = ~clk_tb;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [ND[g]-1:0] rst_w;
        logic             ack_w;
        logic             done_w;
        logic [1:0]       st_w;

        reset_seq_gen #(
            .NUM_DOM  (ND[g]),
            .HOLD_CYC (HC[g]),
            .STEP_CYC (SC[g])
        ) u_dut (
            .clk_i        (clk_tb),
            .rst_n_sync_i (rst_n_sync),
            .sw_rst_req_i (sw_req),
            .sw_rst_ack_o (ack_w),
            .rst_n_o      (rst_w),
            .rst_done_o   (done_w),
            .state_o      (st_w)
        );

        assign dut_val[g] = {st_w, ack_w, done_w, 4'(rst_w)};
    end

    // Expected {state, ack, done, rst_n} at edge e of a sequence whose origin edge is org:
    // domain k is released at org + HOLD + k*STEP.
    function automatic logic [7:0] expect_at(input int g, input int org, input bit sw, input int e);
        int         n_rel;
        int         last_e;
        logic [3:0] rel;
        logic [1:0] st;
        n_rel  = 0;
        last_e = org + HC[g] + (ND[g] - 1) * SC[g];
        for (int k = 0; k < ND[g]; k++) begin
            if (org + HC[g] + k * SC[g] <= e) n_rel++;
        end
        rel = 4'((1 << n_rel) - 1);
        st  = (n_rel == 0) ? 2'd1 : ((n_rel < ND[g]) ? 2'd2 : 2'd3);
        return {st, (sw && (e == last_e)), (n_rel == ND[g]), rel};
    endfunction

    // reference model: pushes every predicted output change onto the scoreboard
    initial begin
        int         org [NI];
        bit         sw_m [NI];
        bit         in_seq [NI];
        bit         prev_req [NI];
        logic [7:0] last_exp [NI];
        logic [7:0] before_exp [NI];
        logic [7:0] exp_v;
        logic       pc;
        logic       pr;
        bit         is_pos;
        for (int g = 0; g < NI; g++) begin
            org[g] = 0; sw_m[g] = 1'b0; in_seq[g] = 1'b0; prev_req[g] = 1'b0;
            last_exp[g] = 8'h00; before_exp[g] = 8'h00;
        end
        pc = 1'b0;
        pr = 1'b0;
        forever begin
            @(clk_tb or rst_n_sync);
            is_pos = (clk_tb === 1'b1) && (pc === 1'b0);
            pc = clk_tb;
            if (is_pos) begin
                cyc++;
                for (int g = 0; g < NI; g++) begin
                    before_exp[g] = last_exp[g];
                    if (rst_n_sync !== 1'b1) begin
                        in_seq[g] = 1'b0; prev_req[g] = 1'b0; exp_v = 8'h00;
                    end else begin
                        if (!in_seq[g]) begin
                            in_seq[g] = 1'b1; org[g] = cyc; sw_m[g] = 1'b0;
                        end else if (sw_req && !prev_req[g] &&
                                     cyc > org[g] + HC[g] + (ND[g] - 1) * SC[g]) begin
                            org[g] = cyc; sw_m[g] = 1'b1;
                        end
                        prev_req[g] = sw_req;
                        exp_v = expect_at(g, org[g], sw_m[g], cyc);
                    end
                    if (exp_v !== last_exp[g]) begin
                        sb_q.push_back('{inst: g, edge_n: cyc, val: exp_v});
                        last_exp[g] = exp_v;
                    end
                end
            end else if (pr === 1'b1 && rst_n_sync === 1'b0) begin
                // async clear after this edge's update: that update is never observed
                for (int g = 0; g < NI; g++) begin
                    for (int i = sb_q.size() - 1; i >= 0; i--) begin
                        if (sb_q[i].inst == g && sb_q[i].edge_n == cyc) begin
                            sb_q.delete(i);
                            last_exp[g] = before_exp[g];
                        end
                    end
                    in_seq[g] = 1'b0; prev_req[g] = 1'b0;
                    if (last_exp[g] !== 8'h00) begin
                        sb_q.push_back('{inst: g, edge_n: cyc, val: 8'h00});
                        last_exp[g] = 8'h00;
                    end
                end
            end
            pr = rst_n_sync;
        end
    end

    // monitor: on every observed output change pop the oldest prediction for that instance
    initial begin
        logic [7:0] prev_val [NI];
        int         idx;
        int         left;
        for (int g = 0; g < NI; g++) prev_val[g] = 8'h00;
        forever begin
            @(negedge clk_tb);
            for (int g = 0; g < NI; g++) begin
                if (dut_val[g] !== prev_val[g]) begin
                    idx = -1;
                    for (int i = 0; i < sb_q.size(); i++) begin
                        if (idx < 0 && sb_q[i].inst == g) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_change inst %0d edge %0d got %h required no change",
                                 g, cyc, dut_val[g]);
                    end else begin
                        if (sb_q[idx].edge_n != cyc || sb_q[idx].val !== dut_val[g]) begin
                            errors++;
                            $display("FAIL out_event inst %0d got %h at edge %0d required %h at edge %0d",
                                     g, dut_val[g], cyc, sb_q[idx].val, sb_q[idx].edge_n);
                        end
                        sb_q.delete(idx);
                    end
                    prev_val[g] = dut_val[g];
                end
            end
            if (stim_done) begin
                for (int g = 0; g < NI; g++) begin
                    left = 0;
                    for (int i = 0; i < sb_q.size(); i++) begin
                        if (sb_q[i].inst == g) left++;
                    end
                    checks++;
                    if (left != 0) begin
                        errors++;
                        $display("FAIL missing_events inst %0d got %0d unobserved required 0", g, left);
                    end
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_tb);
        #1;
    endtask

    task automatic async_reset(input int hold);
        @(posedge clk_tb);
        #1 rst_n_sync = 1'b0;
        wait_cyc(hold);
        rst_n_sync = 1'b1;
    endtask

    // stimulus: directed scenarios first, then randomized request and reset traffic
    initial begin
        rst_n_sync = 1'b0;
        sw_req     = 1'b0;
        wait_cyc(3);
        rst_n_sync = 1'b1;
        wait_cyc(6);
        sw_req = 1'b1;
        wait_cyc(2);
        sw_req = 1'b0;
        wait_cyc(30);
        sw_req = 1'b1;
        wait_cyc(1);
        sw_req = 1'b0;
        wait_cyc(30);
        sw_req = 1'b1;
        wait_cyc(40);
        sw_req = 1'b0;
        wait_cyc(2);
        sw_req = 1'b1;
        wait_cyc(2);
        sw_req = 1'b0;
        wait_cyc(30);
        sw_req = 1'b1;
        wait_cyc(1);
        sw_req = 1'b0;
        wait_cyc(17);
        async_reset(3);
        wait_cyc(18);
        async_reset(2);
        wait_cyc(30);
        sw_req = 1'b1;
        async_reset(4);
        sw_req = 1'b0;
        wait_cyc(30);
        for (int i = 0; i < 900; i++) begin
            wait_cyc(1);
            if ($urandom_range(0, 7) == 0) sw_req = ~sw_req;
            if ($urandom_range(0, 249) == 0) async_reset(int'($urandom_range(1, 3)));
        end
        sw_req = 1'b0;
        wait_cyc(40);
        stim_done = 1'b1;
    end

endmodule
